kf_predict_unit: RTL and testbench



---
 rtl/kf_predict_unit.sv | 146 ++++++++++++++
 tb/tb_kf_predict_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/kf_predict_unit.sv
// Kalman predict stage for a 6-state constant-velocity tracker (Q15).
// Latches X/P on start, then emits Xp then Pp one element per clock, saturated to 16 bits.
module kf_predict_unit (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [15:0]  dt,
   input  logic [15:0]  q_pos,
   input  logic [15:0]  q_vel,
   input  logic [95:0]  X_in,
   input  logic [575:0] P_in,
   output logic [95:0]  Xp,
   output logic [575:0] Pp,
   output logic         busy,
   output logic         done
);
   typedef enum logic [1:0] {IDLE, DT2, XST, COV} state_t;

   state_t              state;
   logic [5:0]          idx;
   logic [2:0]          row, col;
   logic signed [15:0]  dt_r, qp_r, qv_r;
   logic signed [16:0]  dt2_r;
   logic [95:0]         x_r;
   logic [575:0]        p_r;

   function automatic logic signed [33:0] ext(input logic signed [15:0] v);
      return 34'(v);
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
      if (v > 34'sd32767)       return 16'sh7fff;
      else if (v < -34'sd32768) return 16'sh8000;
      else                      return v[15:0];
   endfunction

   logic [5:0]          k3, k18, k21;
   logic [2:0]          xs, xs3;
   logic                rlo, clo, diag;
   logic signed [33:0]  dtx, dt2x, pc, pa, pb, pd, t_a, t_b, t_ab, t_d, p_sum;
   logic signed [33:0]  xc, xv, x_sum;
   logic signed [15:0]  x_next, p_next;

   // Neighbour indices fall back to idx when the term is unused, so every read stays in range.
   always_comb begin
      rlo   = row < 3'd3;
      clo   = col < 3'd3;
      diag  = row == col;
      k3    = clo ? idx + 6'd3 : idx;
      k18   = rlo ? idx + 6'd18 : idx;
      k21   = (rlo && clo) ? idx + 6'd21 : idx;
      dtx   = ext(dt_r);
      dt2x  = 34'(dt2_r);
      pc    = ext(p_r[16*idx +: 16]);
      pa    = ext(p_r[16*k18 +: 16]);
      pb    = ext(p_r[16*k3 +: 16]);
      pd    = ext(p_r[16*k21 +: 16]);
      t_a   = (dtx * pa) >>> 15;
      t_b   = (dtx * pb) >>> 15;
      t_ab  = (dtx * (pa + pb)) >>> 15;
      t_d   = (dt2x * pd) >>> 15;
      case ({rlo, clo})
         2'b11:   p_sum = pc + t_ab + t_d + (diag ? ext(qp_r) : 34'sd0);
         2'b10:   p_sum = pc + t_a;
         2'b01:   p_sum = pc + t_b;
         default: p_sum = pc + (diag ? ext(qv_r) : 34'sd0);
      endcase
      p_next = sat16(p_sum);

      xs     = (idx < 6'd6) ? idx[2:0] : 3'd0;
      xs3    = (xs < 3'd3) ? xs + 3'd3 : xs;
      xc     = ext(x_r[16*xs +: 16]);
      xv     = ext(x_r[16*xs3 +: 16]);
      x_sum  = (xs < 3'd3) ? xc + ((dtx * xv) >>> 15) : xc;
      x_next = sat16(x_sum);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         row   <= '0;
         col   <= '0;
         dt_r  <= '0;
         qp_r  <= '0;
         qv_r  <= '0;
         dt2_r <= '0;
         x_r   <= '0;
         p_r   <= '0;
         Xp    <= '0;
         Pp    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               dt_r  <= dt;
               qp_r  <= q_pos;
               qv_r  <= q_vel;
               x_r   <= X_in;
               p_r   <= P_in;
               busy  <= 1'b1;
               idx   <= '0;
               state <= DT2;
            end
            DT2: begin
               dt2_r <= 17'((dtx * dtx) >>> 15);
               idx   <= '0;
               row   <= '0;
               col   <= '0;
               state <= XST;
            end
            XST: begin
               Xp[16*idx +: 16] <= x_next;
               if (idx == 6'd5) begin
                  idx   <= '0;
                  state <= COV;
               end else begin
                  idx <= idx + 6'd1;
               end
            end
            COV: begin
               Pp[16*idx +: 16] <= p_next;
               if (idx == 6'd35) begin
                  idx   <= '0;
                  row   <= '0;
                  col   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  idx <= idx + 6'd1;
                  if (col == 3'd5) begin
                     col <= '0;
                     row <= row + 3'd1;
                  end else begin
                     col <= col + 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_kf_predict_unit.sv
// Directed + randomized bench for kf_predict_unit against an integer reference of the predict equations.
module tb_kf_predict_unit;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [15:0]  dt = '0, q_pos = '0, q_vel = '0;
   logic [95:0]  X_in = '0;
   logic [575:0] P_in = '0;
   logic [95:0]  Xp;
   logic [575:0] Pp;
   logic         busy, done;

   int ncmp = 0, nfail = 0;
   int mx[6], mp[36], mdt, mqp, mqv, ex[6], ep[36];

   kf_predict_unit dut (
      .clk(clk), .rst(rst), .start(start), .dt(dt), .q_pos(q_pos), .q_vel(q_vel),
      .X_in(X_in), .P_in(P_in), .Xp(Xp), .Pp(Pp), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int expv);
      ncmp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int sat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic int rnd16();
      logic signed [15:0] v;
      v = 16'($urandom);
      return int'(v);
   endfunction

   function automatic longint mulq(input longint a, input longint b);
      return (a * b) >>> 15;
   endfunction

   function automatic int xo(input int i);
      logic signed [15:0] v;
      v = Xp[16*i +: 16];
      return int'(v);
   endfunction

   function automatic int po(input int k);
      logic signed [15:0] v;
      v = Pp[16*k +: 16];
      return int'(v);
   endfunction

   // Reference: X- = F X and P- = F P F' + Q, term by term with floor-shifted Q15 products.
   task automatic model();
      longint d2, s;
      d2 = mulq(mdt, mdt);
      for (int i = 0; i < 6; i++)
         ex[i] = (i < 3) ? sat(mx[i] + mulq(mdt, mx[i+3])) : mx[i];
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) begin
            s = mp[6*r+c];
            if (r < 3 && c < 3)
               s += mulq(mdt, mp[6*(r+3)+c] + mp[6*r+c+3]) + mulq(d2, mp[6*(r+3)+c+3]) + ((r == c) ? mqp : 0);
            else if (r < 3)
               s += mulq(mdt, mp[6*(r+3)+c]);
            else if (c < 3)
               s += mulq(mdt, mp[6*r+c+3]);
            else
               s += (r == c) ? mqv : 0;
            ep[6*r+c] = sat(s);
         end
   endtask

   task automatic drive();
      dt = 16'(mdt); q_pos = 16'(mqp); q_vel = 16'(mqv);
      for (int i = 0; i < 6; i++)  X_in[16*i +: 16] = 16'(mx[i]);
      for (int k = 0; k < 36; k++) P_in[16*k +: 16] = 16'(mp[k]);
   endtask

   task automatic randomize_all();
      mdt = rnd16(); mqp = rnd16(); mqv = rnd16();
      for (int i = 0; i < 6; i++)  mx[i] = rnd16();
      for (int k = 0; k < 36; k++) mp[k] = rnd16();
   endtask

   // One prediction; optionally pulses start again extra_at cycles after the accepting edge.
   task automatic go(input string tag, input int extra_at);
      int n;
      n = 0;
      model();
      drive();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, int'(busy), 1);
      dt = 16'($urandom); q_pos = 16'($urandom); q_vel = 16'($urandom);
      for (int i = 0; i < 6; i++)  X_in[16*i +: 16] = 16'($urandom);
      for (int k = 0; k < 36; k++) P_in[16*k +: 16] = 16'($urandom);
      while (done !== 1'b1 && n < 100) begin
         tick();
         n++;
         start = (n == extra_at);
      end
      start = 1'b0;
      chk({tag, "_latency"}, n, 43);
      for (int i = 0; i < 6; i++)  chk($sformatf("%s_Xp%0d", tag, i), xo(i), ex[i]);
      for (int k = 0; k < 36; k++) chk($sformatf("%s_Pp%0d", tag, k), po(k), ep[k]);
   endtask

   initial begin
      int seen;
      // Reset with start held high throughout: nothing may launch.
      start = 1'b1;
      tick(); tick();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_Xp", int'(|Xp), 0);
      chk("rst_Pp", int'(|Pp), 0);
      rst = 1'b0; start = 1'b0;
      seen = 0;
      repeat (5) begin tick(); if (busy || done) seen++; end
      chk("rst_nolaunch", seen, 0);

      // Nominal directed case.
      mdt = 16'h4000; mqp = 16; mqv = 8;
      mx = '{1000, -500, 0, 2000, 1000, -400};
      for (int k = 0; k < 36; k++) mp[k] = (k % 7 == 0) ? 4096 : 0;
      go("nom", 0);
      chk("nom_Xp0", xo(0), 2000);
      chk("nom_Xp2", xo(2), -200);
      chk("nom_Pp0", po(0), 5136);
      chk("nom_Pp3", po(3), 2048);
      chk("nom_Pp18", po(18), 2048);
      chk("nom_Pp21", po(21), 4104);
      tick();
      chk("nom_done_pulse", int'(done), 0);
      chk("nom_busy_after", int'(busy), 0);
      chk("nom_hold_Pp0", po(0), 5136);

      // Saturation of the position update.
      randomize_all();
      mdt = 32767; mx[0] = 32000; mx[3] = 32767;
      go("satp", 0);
      chk("satp_Xp0", xo(0), 32767);
      randomize_all();
      mdt = 32767; mx[0] = -32000; mx[3] = -32768;
      go("satn", 0);
      chk("satn_Xp0", xo(0), -32768);

      // Zero dt is identity on both X and P.
      randomize_all();
      mdt = 0; mqp = 0; mqv = 0;
      go("zdt", 0);
      for (int i = 0; i < 6; i++)  chk($sformatf("zdt_id_X%0d", i), xo(i), mx[i]);
      for (int k = 0; k < 36; k++) chk($sformatf("zdt_id_P%0d", k), po(k), mp[k]);

      // start while busy is ignored.
      randomize_all();
      go("ign", 10);
      tick();
      chk("ign_no_rerun", int'(busy), 0);

      // Back-to-back: second start lands in the done cycle.
      randomize_all();
      go("b2b_a", 0);
      randomize_all();
      go("b2b_b", 0);

      // Randomized runs, including the most negative dt.
      for (int t = 0; t < 4; t++) begin
         randomize_all();
         if (t == 0) mdt = -32768;
         go($sformatf("rnd%0d", t), 0);
      end

      // Reset mid-run.
      randomize_all();
      model();
      drive();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_busy", int'(busy), 0);
      chk("mid_done", int'(done), 0);
      chk("mid_Xp", int'(|Xp), 0);
      chk("mid_Pp", int'(|Pp), 0);
      seen = 0;
      repeat (60) begin tick(); if (done || busy) seen++; end
      chk("mid_nodone", seen, 0);
      randomize_all();
      go("post", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
